// File: rtl/pc_hazard_controller.sv
// PC / pipeline-register sequencer for the 5-stage MIPS datapath: load-use stalls,
// branch/jump redirects, data-memory waits, plus a saturating stall counter and watchdog.
module pc_hazard_controller #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WDOG_MAX = 255
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             EX_BranchTaken,
  input  logic             ID_Jump,
  input  logic             MemBusy,
  input  logic             MemDone,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic [CNT_W-1:0] StallCount,
  output logic             Timeout,
  output logic [1:0]       State
);

  localparam int unsigned WD_W = $clog2(WDOG_MAX + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  logic              lu;
  logic              pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]        pc_sel;

  // $zero is never a real producer, so a load targeting it cannot create a hazard
  assign lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
              ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    pc_write    = 1'b0;
    pc_sel      = 2'b00;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;

    case (state_q)
      RUN, LU_STALL: begin
        if (MemBusy) begin
          state_d = MEM_WAIT;
        end else if (EX_BranchTaken) begin
          pc_write    = 1'b1;
          pc_sel      = 2'b10;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = RUN;
        end else if (lu && (state_q == RUN)) begin
          idex_bubble = 1'b1;
          state_d     = LU_STALL;
        end else if (ID_Jump) begin
          pc_write    = 1'b1;
          pc_sel      = 2'b01;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          state_d     = RUN;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          state_d     = RUN;
        end
      end
      MEM_WAIT: begin
        if (MemDone) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    // Count is 1 during the first MEM_WAIT cycle, so Timeout rises at the edge
    // that closes the WDOG_MAX-th waiting cycle.
    wdog_d = '0;
    if (state_d == MEM_WAIT) begin
      if (state_q != MEM_WAIT) begin
        wdog_d = WD_W'(1);
      end else if (wdog_q != WD_W'(WDOG_MAX)) begin
        wdog_d = wdog_q + WD_W'(1);
      end else begin
        wdog_d = wdog_q;
      end
    end

    timeout_d = timeout_q || ((state_q == MEM_WAIT) && (wdog_q == WD_W'(WDOG_MAX)));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= RUN;
      stall_q   <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    if (!Reset) begin
      PCWrite    = 1'b0;
      PCSel      = 2'b00;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else begin
      PCWrite    = pc_write;
      PCSel      = pc_sel;
      IFIDWrite  = ifid_write;
      IFIDFlush  = ifid_flush;
      IDEXBubble = idex_bubble;
    end
  end

  assign StallCount = stall_q;
  assign Timeout    = timeout_q;
  assign State      = state_q;

endmodule

// File: tb/tb_pc_hazard_controller.sv
// Directed bench for pc_hazard_controller: a default instance plus a small one
// (CNT_W=4, WDOG_MAX=8) for saturation and watchdog corners.
module tb_pc_hazard_controller;

  logic        Clk;
  logic        Reset;
  logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rt;
  logic        IFID_UsesRt, IDEX_MemRead, EX_BranchTaken, ID_Jump, MemBusy, MemDone;

  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Timeout;
  logic [1:0]  PCSel, State;
  logic [15:0] StallCount;

  logic        PCWrite_s, IFIDWrite_s, IFIDFlush_s, IDEXBubble_s, Timeout_s;
  logic [1:0]  PCSel_s, State_s;
  logic [3:0]  StallCount_s;

  int compared   = 0;
  int mismatched = 0;

  pc_hazard_controller dut (
    .Clk(Clk), .Reset(Reset),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump),
    .MemBusy(MemBusy), .MemDone(MemDone),
    .PCWrite(PCWrite), .PCSel(PCSel), .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
    .StallCount(StallCount), .Timeout(Timeout), .State(State)
  );

  pc_hazard_controller #(.CNT_W(4), .WDOG_MAX(8)) dut_s (
    .Clk(Clk), .Reset(Reset),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump),
    .MemBusy(MemBusy), .MemDone(MemDone),
    .PCWrite(PCWrite_s), .PCSel(PCSel_s), .IFIDWrite(IFIDWrite_s),
    .IFIDFlush(IFIDFlush_s), .IDEXBubble(IDEXBubble_s),
    .StallCount(StallCount_s), .Timeout(Timeout_s), .State(State_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memrd;
    logic [4:0] idex_rt;
    logic       br;
    logic       jmp;
    logic       busy;
    logic       pcw;
    logic [1:0] sel;
    logic       ifw;
    logic       ifw_care;
    logic       fl;
    logic       bu;
    logic [1:0] nst;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0;
    EX_BranchTaken = 1'b0; ID_Jump = 1'b0; MemBusy = 1'b0; MemDone = 1'b0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    //              rs  rt  use mr irt br jmp bsy  pcw sel    ifw care fl bu nst
    vecs[0] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0,   1, 2'b00, 1, 1,   0, 0, 2'b00}; // idle
    vecs[1] = '{5'd8, 5'd3, 0, 1, 5'd8, 0, 0, 0,   0, 2'b00, 0, 1,   0, 1, 2'b01}; // lu on rs
    vecs[2] = '{5'd3, 5'd8, 1, 1, 5'd8, 0, 0, 0,   0, 2'b00, 0, 1,   0, 1, 2'b01}; // lu on rt
    vecs[3] = '{5'd3, 5'd8, 0, 1, 5'd8, 0, 0, 0,   1, 2'b00, 1, 1,   0, 0, 2'b00}; // rt not a source
    vecs[4] = '{5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0,   1, 2'b00, 1, 1,   0, 0, 2'b00}; // $zero never stalls
    vecs[5] = '{5'd8, 5'd8, 1, 0, 5'd8, 0, 0, 0,   1, 2'b00, 1, 1,   0, 0, 2'b00}; // not a load
    vecs[6] = '{5'd8, 5'd3, 0, 1, 5'd8, 1, 1, 0,   1, 2'b10, 0, 0,   1, 1, 2'b00}; // branch beats lu+jump
    vecs[7] = '{5'd1, 5'd2, 0, 0, 5'd5, 0, 1, 0,   1, 2'b01, 0, 0,   1, 0, 2'b00}; // jump
    vecs[8] = '{5'd8, 5'd3, 0, 1, 5'd8, 1, 1, 1,   0, 2'b00, 0, 1,   0, 0, 2'b10}; // mem busy beats all
    vecs[9] = '{5'd9, 5'd3, 0, 1, 5'd9, 0, 1, 0,   0, 2'b00, 0, 1,   0, 1, 2'b01}; // lu beats jump

    clear_inputs();
    EX_BranchTaken = 1'b1;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_pcw", PCWrite, 0);
    chk("rst_ifw", IFIDWrite, 0);
    chk("rst_flush", IFIDFlush, 1);
    chk("rst_bubble", IDEXBubble, 1);
    chk("rst_sel", PCSel, 0);
    chk("rst_state", State, 0);
    chk("rst_stall", StallCount, 0);
    chk("rst_timeout", Timeout, 0);

    EX_BranchTaken = 1'b0;
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("idle_pcw", PCWrite, 1);
      chk("idle_sel", PCSel, 0);
      tick();
    end
    chk("idle_stall", StallCount, 0);
    chk("idle_state", State, 0);

    for (int i = 0; i < 10; i++) begin
      pulse_reset();
      IFID_Rs = vecs[i].rs; IFID_Rt = vecs[i].rt; IFID_UsesRt = vecs[i].uses_rt;
      IDEX_MemRead = vecs[i].memrd; IDEX_Rt = vecs[i].idex_rt;
      EX_BranchTaken = vecs[i].br; ID_Jump = vecs[i].jmp; MemBusy = vecs[i].busy;
      #2;
      chk($sformatf("v%0d_pcw", i), PCWrite, vecs[i].pcw);
      chk($sformatf("v%0d_sel", i), PCSel, vecs[i].sel);
      if (vecs[i].ifw_care) chk($sformatf("v%0d_ifw", i), IFIDWrite, vecs[i].ifw);
      chk($sformatf("v%0d_flush", i), IFIDFlush, vecs[i].fl);
      chk($sformatf("v%0d_bubble", i), IDEXBubble, vecs[i].bu);
      tick();
      chk($sformatf("v%0d_state", i), State, vecs[i].nst);
      chk($sformatf("v%0d_stall", i), StallCount, vecs[i].pcw ? 0 : 1);
      clear_inputs();
    end

    // load-use: one stall cycle, lu ignored while in LU_STALL
    pulse_reset();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    #2;
    chk("lu1_pcw", PCWrite, 0);
    chk("lu1_ifw", IFIDWrite, 0);
    chk("lu1_bubble", IDEXBubble, 1);
    tick();
    chk("lu_state1", State, 1);
    #2;
    chk("lu2_pcw", PCWrite, 1);
    chk("lu2_ifw", IFIDWrite, 1);
    chk("lu2_bubble", IDEXBubble, 0);
    tick();
    chk("lu_state2", State, 0);
    chk("lu_stall", StallCount, 1);
    IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
    #2;
    chk("lu_r0_pcw", PCWrite, 1);
    tick();
    chk("lu_r0_state", State, 0);
    chk("lu_r0_stall", StallCount, 1);
    clear_inputs();

    // memory wait: busy pulse, done 4 cycles later (busy also high then)
    pulse_reset();
    MemBusy = 1'b1;
    #2;
    chk("mw0_pcw", PCWrite, 0);
    chk("mw0_bubble", IDEXBubble, 0);
    tick();
    MemBusy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mw%0d_state", k), State, 2);
      EX_BranchTaken = (k == 2);
      ID_Jump = (k == 2);
      if (k == 4) begin
        MemDone = 1'b1;
        MemBusy = 1'b1;
      end
      #2;
      chk($sformatf("mw%0d_pcw", k), PCWrite, 0);
      chk($sformatf("mw%0d_flush", k), IFIDFlush, 0);
      chk($sformatf("mw%0d_bubble", k), IDEXBubble, 0);
      chk($sformatf("mw%0d_sel", k), PCSel, 0);
      tick();
    end
    clear_inputs();
    chk("mw_exit_state", State, 0);
    #2;
    chk("mw_exit_pcw", PCWrite, 1);
    chk("mw_stall", StallCount, 5);

    // watchdog on the small instance
    pulse_reset();
    MemBusy = 1'b1;
    tick();
    MemBusy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("wd%0d_timeout", k), Timeout_s, (k >= 8) ? 1 : 0);
      chk($sformatf("wd%0d_state", k), State_s, 2);
    end
    chk("wd_default_timeout", Timeout, 0);
    MemDone = 1'b1;
    tick();
    MemDone = 1'b0;
    chk("wd_exit_state", State_s, 0);
    chk("wd_exit_timeout", Timeout_s, 1);

    // saturation, then asynchronous reset mid-wait
    pulse_reset();
    MemBusy = 1'b1;
    tick();
    MemBusy = 1'b0;
    repeat (20) tick();
    chk("sat_stall_s", StallCount_s, 15);
    chk("sat_stall", StallCount, 21);
    chk("sat_state", State_s, 2);
    chk("sat_timeout_s", Timeout_s, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_state", State, 0);
    chk("arst_state_s", State_s, 0);
    chk("arst_stall", StallCount, 0);
    chk("arst_stall_s", StallCount_s, 0);
    chk("arst_timeout_s", Timeout_s, 0);
    chk("arst_flush", IFIDFlush, 1);
    chk("arst_pcw", PCWrite, 0);
    Reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
